// File: rtl/banked_mem_pkg.sv
// Shared helpers for the banked memory: width derivation and address field extraction.
// Addresses are split as {bank, word} with the bank index in the upper bits.
package banked_mem_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 32'd0;
        while ((32'd1 << width) < value) begin
            width = width + 32'd1;
        end
        return width;
    endfunction

    // Field widths for the default 16 x 128 geometry.
    localparam int unsigned BANK_W = clog2(32'd16);
    localparam int unsigned WORD_W = clog2(32'd128);

    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned word_w);
        return addr >> word_w;
    endfunction

    function automatic int unsigned word_of(input int unsigned addr, input int unsigned word_w);
        return addr & ((32'd1 << word_w) - 32'd1);
    endfunction

endpackage

// File: rtl/banked_rw_memory_if.sv
// Read/write port bundle of the banked memory; the master drives requests, the slave answers.
interface banked_rw_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) ();
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] din;
    logic              wready;
    logic              rvalid;
    logic [DATA_W-1:0] dout;
    logic              pend;

    modport master (
        output ren, raddr, wen, waddr, din,
        input  wready, rvalid, dout, pend
    );

    modport slave (
        input  ren, raddr, wen, waddr, din,
        output wready, rvalid, dout, pend
    );
endinterface

// File: rtl/banked_rw_memory_sram.sv
// Single-port bank array with a registered read port; contents are never reset.
module bank_sram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // One access per cycle: a write updates the array, a read updates rdata.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end else begin
                rdata <= mem_r[addr];
            end
        end
    end
endmodule

// File: rtl/banked_rw_memory.sv
// Banked byte memory with independent read and write ports; a one-entry write buffer
// parks writes that collide with a read in the same bank and forwards them to reads.
module banked_rw_memory
    import banked_mem_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BANK_CNT   = 16,
    parameter int BANK_DEPTH = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    banked_rw_memory_if.slave  bus
);
    localparam int unsigned BANK_BITS = clog2(BANK_CNT);
    localparam int unsigned WORD_BITS = clog2(BANK_DEPTH);
    localparam int unsigned ADDR_W    = BANK_BITS + WORD_BITS;

    logic [BANK_BITS-1:0] rbank_s;
    logic [BANK_BITS-1:0] wbank_s;
    logic [BANK_BITS-1:0] bbank_s;
    logic [WORD_BITS-1:0] rword_s;
    logic [WORD_BITS-1:0] wword_s;
    logic [WORD_BITS-1:0] bword_s;

    logic              pend_r;
    logic [ADDR_W-1:0] buf_addr_r;
    logic [DATA_W-1:0] buf_data_r;

    logic wr_accept_s;
    logic buf_load_s;
    logic wr_direct_s;
    logic drain_s;
    logic fwd_s;

    logic                 rvalid_r;
    logic [BANK_BITS-1:0] rd_bank_r;
    logic                 fwd_r;
    logic [DATA_W-1:0]    fwd_data_r;
    logic [DATA_W-1:0]    dout_s;

    logic                 bank_en_s    [BANK_CNT];
    logic                 bank_we_s    [BANK_CNT];
    logic [WORD_BITS-1:0] bank_addr_s  [BANK_CNT];
    logic [DATA_W-1:0]    bank_wdata_s [BANK_CNT];
    logic [DATA_W-1:0]    bank_rdata_s [BANK_CNT];

    assign rbank_s = BANK_BITS'(bank_of(32'(bus.raddr), WORD_BITS));
    assign wbank_s = BANK_BITS'(bank_of(32'(bus.waddr), WORD_BITS));
    assign bbank_s = BANK_BITS'(bank_of(32'(buf_addr_r), WORD_BITS));
    assign rword_s = WORD_BITS'(word_of(32'(bus.raddr), WORD_BITS));
    assign wword_s = WORD_BITS'(word_of(32'(bus.waddr), WORD_BITS));
    assign bword_s = WORD_BITS'(word_of(32'(buf_addr_r), WORD_BITS));

    // A write is only taken while the buffer is empty, so drain and new write never coincide.
    assign wr_accept_s = bus.wen && !pend_r;
    assign buf_load_s  = wr_accept_s && bus.ren && (wbank_s == rbank_s);
    assign wr_direct_s = wr_accept_s && !buf_load_s;
    assign drain_s     = pend_r && !(bus.ren && (rbank_s == bbank_s));
    assign fwd_s       = bus.ren && pend_r && (bus.raddr == buf_addr_r);

    // Per-bank arbitration: read beats buffer drain, which beats a new direct write.
    always_comb begin
        for (int b = 0; b < BANK_CNT; b++) begin
            bank_en_s[b]    = 1'b0;
            bank_we_s[b]    = 1'b0;
            bank_addr_s[b]  = '0;
            bank_wdata_s[b] = '0;
            if (bus.ren && (rbank_s == BANK_BITS'(b))) begin
                bank_en_s[b]   = 1'b1;
                bank_addr_s[b] = rword_s;
            end else if (drain_s && (bbank_s == BANK_BITS'(b))) begin
                bank_en_s[b]    = 1'b1;
                bank_we_s[b]    = 1'b1;
                bank_addr_s[b]  = bword_s;
                bank_wdata_s[b] = buf_data_r;
            end else if (wr_direct_s && (wbank_s == BANK_BITS'(b))) begin
                bank_en_s[b]    = 1'b1;
                bank_we_s[b]    = 1'b1;
                bank_addr_s[b]  = wword_s;
                bank_wdata_s[b] = bus.din;
            end else begin
                bank_en_s[b] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < BANK_CNT; g++) begin : g_bank
        bank_sram #(
            .DATA_W (DATA_W),
            .DEPTH  (BANK_DEPTH),
            .AW     (WORD_BITS)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en_s[g]),
            .we    (bank_we_s[g]),
            .addr  (bank_addr_s[g]),
            .wdata (bank_wdata_s[g]),
            .rdata (bank_rdata_s[g])
        );
    end

    // Write buffer: filled on a same-bank conflict, emptied once its bank is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= 1'b0;
            buf_addr_r <= '0;
            buf_data_r <= '0;
        end else if (buf_load_s) begin
            pend_r     <= 1'b1;
            buf_addr_r <= bus.waddr;
            buf_data_r <= bus.din;
        end else if (drain_s) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= pend_r;
        end
    end

    // Read-side state captured alongside the bank access so dout lines up with rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r   <= 1'b0;
            rd_bank_r  <= '0;
            fwd_r      <= 1'b0;
            fwd_data_r <= '0;
        end else begin
            rvalid_r   <= bus.ren;
            rd_bank_r  <= rbank_s;
            fwd_r      <= fwd_s;
            fwd_data_r <= buf_data_r;
        end
    end

    // Output select: zero when idle, buffered data when forwarded, else the bank read.
    always_comb begin
        dout_s = '0;
        if (!rvalid_r) begin
            dout_s = '0;
        end else if (fwd_r) begin
            dout_s = fwd_data_r;
        end else begin
            dout_s = bank_rdata_s[rd_bank_r];
        end
    end

    assign bus.dout   = dout_s;
    assign bus.rvalid = rvalid_r;
    assign bus.pend   = pend_r;
    assign bus.wready = !pend_r;

endmodule

// File: tb/tb_banked_rw_memory.sv
// Randomised and directed bench for banked_rw_memory against an address-level reference model.
module tb_banked_rw_memory;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_conf = 0, n_fwd = 0, n_blk = 0;

    // Reference model: flat memory plus an optional pending write.
    logic [7:0] m_mem [2048];
    bit         m_pend = 1'b0;
    int         m_baddr = 0;
    logic [7:0] m_bdata = 8'h00;

    always #5 clk = ~clk;

    banked_rw_memory_if #(.DATA_W(8), .ADDR_W(11)) bus ();
    banked_rw_memory #(.DATA_W(8), .BANK_CNT(16), .BANK_DEPTH(128)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    banked_rw_memory_if #(.DATA_W(16), .ADDR_W(7)) bus2 ();
    banked_rw_memory #(.DATA_W(16), .BANK_CNT(4), .BANK_DEPTH(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    function automatic int bank_of_addr(input int a);
        return a / 128;
    endfunction

    task automatic step(input bit r, input int ra, input bit w, input int wa, input logic [7:0] d);
        logic [7:0] exp_d;
        bit         acc;
        bus.ren = r; bus.raddr = 11'(ra); bus.wen = w; bus.waddr = 11'(wa); bus.din = d;
        exp_d = 8'h00;
        if (r) begin
            if (m_pend && ra == m_baddr) begin
                exp_d = m_bdata;
                n_fwd++;
            end else begin
                exp_d = m_mem[ra];
            end
        end
        acc = w && !m_pend;
        if (w && m_pend) n_blk++;
        if (m_pend && !(r && bank_of_addr(ra) == bank_of_addr(m_baddr))) begin
            m_mem[m_baddr] = m_bdata;
            m_pend = 1'b0;
        end
        if (acc) begin
            if (r && bank_of_addr(wa) == bank_of_addr(ra)) begin
                m_pend = 1'b1; m_baddr = wa; m_bdata = d;
                n_conf++;
            end else begin
                m_mem[wa] = d;
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.rvalid !== r) begin
            n_fail++; $display("FAIL rvalid t=%0t got %b exp %b", $time, bus.rvalid, r);
        end
        n_tests++;
        if (bus.dout !== exp_d) begin
            n_fail++; $display("FAIL dout t=%0t raddr=%h got %h exp %h", $time, ra, bus.dout, exp_d);
        end
        n_tests++;
        if (bus.pend !== m_pend) begin
            n_fail++; $display("FAIL pend t=%0t got %b exp %b", $time, bus.pend, m_pend);
        end
        n_tests++;
        if (bus.wready !== !m_pend) begin
            n_fail++; $display("FAIL wready t=%0t got %b exp %b", $time, bus.wready, !m_pend);
        end
    endtask

    task automatic test_reset();
        bus.ren = 1'b0; bus.raddr = '0; bus.wen = 1'b0; bus.waddr = '0; bus.din = '0;
        bus2.ren = 1'b0; bus2.raddr = '0; bus2.wen = 1'b0; bus2.waddr = '0; bus2.din = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.dout !== 8'h00 || bus.rvalid !== 1'b0 || bus.pend !== 1'b0 || bus.wready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got dout=%h rvalid=%b pend=%b wready=%b exp 00 0 0 1",
                     bus.dout, bus.rvalid, bus.pend, bus.wready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_diff_banks();
        step(1'b1, 'h085, 1'b1, 'h005, 8'h5A);
        n_tests++;
        if (bus.pend !== 1'b0) begin
            n_fail++; $display("FAIL diff_bank_pend got %b exp 0", bus.pend);
        end
        step(1'b1, 'h005, 1'b0, 0, 8'h00);
        n_tests++;
        if (bus.dout !== 8'h5A) begin
            n_fail++; $display("FAIL diff_bank_read got %h exp 5a", bus.dout);
        end
    endtask

    task automatic test_conflict();
        step(1'b0, 0, 1'b1, 'h013, 8'h11);
        step(1'b1, 'h013, 1'b1, 'h013, 8'h77);
        n_tests++;
        if (bus.dout !== 8'h11 || bus.pend !== 1'b1 || bus.wready !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict got dout=%h pend=%b wready=%b exp 11 1 0", bus.dout, bus.pend, bus.wready);
        end
        step(1'b1, 'h013, 1'b0, 0, 8'h00);
        n_tests++;
        if (bus.dout !== 8'h77) begin
            n_fail++; $display("FAIL forward got %h exp 77", bus.dout);
        end
        step(1'b0, 0, 1'b0, 0, 8'h00);
        step(1'b1, 'h013, 1'b0, 0, 8'h00);
        n_tests++;
        if (bus.dout !== 8'h77 || bus.pend !== 1'b0) begin
            n_fail++; $display("FAIL drained_read got dout=%h pend=%b exp 77 0", bus.dout, bus.pend);
        end
    endtask

    task automatic test_blocked_write();
        step(1'b0, 0, 1'b1, 'h7F0, 8'h33);
        step(1'b1, 'h7F2, 1'b1, 'h7F1, 8'h44);
        step(1'b1, 'h7F3, 1'b1, 'h7F0, 8'hEE);
        step(1'b1, 'h7F0, 1'b0, 0, 8'h00);
        n_tests++;
        if (bus.dout !== 8'h33 || bus.pend !== 1'b1) begin
            n_fail++; $display("FAIL blocked_write got dout=%h pend=%b exp 33 1", bus.dout, bus.pend);
        end
        step(1'b0, 0, 1'b0, 0, 8'h00);
        step(1'b1, 'h7F1, 1'b0, 0, 8'h00);
        step(1'b1, 'h7F0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 0, 1'b1, 'h130, 8'hAB);
        step(1'b1, 'h131, 1'b1, 'h130, 8'hCD);
        step(1'b1, 'h132, 1'b0, 0, 8'h00);
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (bus.dout !== 8'h00 || bus.rvalid !== 1'b0 || bus.pend !== 1'b0 || bus.wready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got dout=%h rvalid=%b pend=%b wready=%b exp 00 0 0 1",
                     bus.dout, bus.rvalid, bus.pend, bus.wready);
        end
        m_pend = 1'b0;
        bus.ren = 1'b0; bus.wen = 1'b0;
        #1;
        rst_n = 1'b1;
        step(1'b1, 'h130, 1'b0, 0, 8'h00);
        n_tests++;
        if (bus.dout !== 8'hAB) begin
            n_fail++; $display("FAIL reset_discard got %h exp ab", bus.dout);
        end
    endtask

    task automatic test_param_sweep();
        for (int i = 0; i < 128; i++) begin
            bus2.wen = 1'b1; bus2.waddr = 7'(i); bus2.din = 16'(i * 3);
            @(posedge clk); #1;
            n_tests++;
            if (bus2.wready !== 1'b1 || bus2.rvalid !== 1'b0) begin
                n_fail++; $display("FAIL sweep_write i=%0d wready=%b rvalid=%b exp 1 0", i, bus2.wready, bus2.rvalid);
            end
        end
        bus2.wen = 1'b0;
        for (int i = 0; i < 128; i++) begin
            bus2.ren = 1'b1; bus2.raddr = 7'(i);
            @(posedge clk); #1;
            n_tests++;
            if (bus2.rvalid !== 1'b1 || bus2.dout !== 16'(i * 3)) begin
                n_fail++;
                $display("FAIL sweep_read i=%0d got rvalid=%b dout=%h exp 1 %h", i, bus2.rvalid, bus2.dout, 16'(i * 3));
            end
        end
        bus2.ren = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (bus2.rvalid !== 1'b0 || bus2.dout !== 16'h0000) begin
            n_fail++; $display("FAIL sweep_idle got rvalid=%b dout=%h exp 0 0000", bus2.rvalid, bus2.dout);
        end
    endtask

    task automatic test_random();
        int ra, wa;
        bit r, w;
        logic [7:0] d;
        for (int c = 0; c < 10000; c++) begin
            ra = int'($urandom_range(0, 3)) * 128 + int'($urandom_range(0, 3));
            wa = int'($urandom_range(0, 3)) * 128 + int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = int'($urandom_range(0, 2047));
            if ($urandom_range(0, 9) == 0) wa = int'($urandom_range(0, 2047));
            r = ($urandom_range(0, 9) < 7);
            w = ($urandom_range(0, 9) < 6);
            d = 8'($urandom);
            step(r, ra, w, wa, d);
        end
        n_tests++;
        if (n_conf == 0 || n_fwd == 0 || n_blk == 0) begin
            n_fail++; $display("FAIL coverage conflicts=%0d forwards=%0d blocked=%0d exp all nonzero", n_conf, n_fwd, n_blk);
        end
    endtask

    initial begin
        test_reset();
        test_diff_banks();
        test_conflict();
        test_blocked_write();
        test_reset_mid();
        test_param_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/banked_rw_memory.md
# banked_rw_memory

Parametrised multi-bank byte memory with one read port and one write port, both usable in the same cycle. Address space is split into `BANK_CNT` single-port banks on the upper address bits. A one-entry write buffer absorbs read/write bank conflicts, and reads of the buffered address are forwarded from it. It supersedes the fixed 4x4x128 banked memory as the general storage block for the lab designs.

## Interface
- `DATA_W`, 8, data width in bits
- `BANK_CNT`, 16, number of banks (power of two, ≥2)
- `BANK_DEPTH`, 128, words per bank (power of two)
- `ADDR_W`, log2(BANK_CNT*BANK_DEPTH) = 11, derived, not overridden

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ren`  in  1  read request
- `raddr`  in  ADDR_W  read address
- `wen`  in  1  write request
- `waddr`  in  ADDR_W  write address
- `din`  in  DATA_W  write data
- `wready`  out  1  write accepted this cycle if `wen` high
- `rvalid`  out  1  `dout` carries read data
- `dout`  out  DATA_W  read data, 0 when `rvalid` low
- `pend`  out  1  write buffer occupied (status)

## Operation
- Bank index = upper log2(BANK_CNT) address bits; word index = remaining lower bits.
- Each bank performs at most one access per cycle. Priority per bank: read > buffered write drain > new write.
- Reads always accepted. Read data comes from the bank array, except: `pend` high and `raddr == buffered address` → data forwarded from buffer.
- `wready = !pend` (combinational from state only, no dependence on `wen`/`ren`).
- Accepted write (`wen && wready`):
  - bank of `waddr` ≠ bank of `raddr`, or `ren` low → written to array at the edge.
  - same bank as an active read → stored in buffer (addr, data); `pend` set next cycle.
- Buffer drain: `pend` high and (`ren` low or bank of `raddr` ≠ buffered bank) → buffered data written to array; `pend` cleared next cycle.
- Same-cycle read and write to the same address (no prior buffer entry): read returns old contents; the write is buffered.
- `wen` while `wready` low: write ignored, no state change; the source retries.
- Array contents are not reset; reading an unwritten location returns X.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): `dout=0`, `rvalid=0`, `pend=0`, `wready=1`; buffer contents cleared.
- Read latency 1: `ren` sampled at edge N → `dout`/`rvalid` valid after edge N, held one cycle; `rvalid` low and `dout=0` in cycles with no read sampled.
- Back-to-back reads every cycle supported; throughput 1 read/cycle.
- Write visibility: a direct write is readable by a read sampled on the next edge. A buffered write is readable on the next edge via forwarding, and from the array after drain.
- Buffer occupancy is at least 1 cycle. With continuous reads to the buffered bank it stays occupied and `wready` stays low (no starvation guarantee; documented limitation).
- Reset mid-buffer: buffered write is discarded.

## Structure
- Shared package `banked_mem_pkg`: `clog2`-derived localparams (`BANK_W`, `WORD_W`), bank/word field extraction functions.
- Sub-module `bank_sram`: single-port `BANK_DEPTH x DATA_W` array with `en`, `we`, `addr`, `wdata`, registered `rdata`. Instantiate `BANK_CNT` copies via generate.
- The top level contains: per-bank arbitration (combinational), the write-buffer registers, the forwarding compare, and the output register/mux.

## Test plan
- Reset mid-traffic: `rst_n` low during active reads with `pend=1` → `dout=0`, `rvalid=0`, `pend=0`, `wready=1` immediately. Afterwards a read of the buffered address returns old/X data, not the buffered value.
- Different banks: write 0x5A to 0x005 and read 0x085 (bank 1) in the same cycle → write direct, `pend` stays 0. A next-cycle read of 0x005 → `dout=0x5A`, `rvalid=1`.
- Same-bank conflict: preload 0x013=0x11. In one cycle, write 0x77 to 0x013 and read 0x013 → `dout=0x11`, `pend=1`, `wready=0`. Read 0x013 next → `dout=0x77` (forwarded). An idle cycle then clears `pend`, and a later read still gives 0x77.
- Blocked write: hold `pend=1` by reading its bank continuously. Present `wen` with 0x7F0=0xEE → ignored. Subsequent read of 0x7F0 shows prior contents.
- Parameter sweep: `DATA_W=16`, `BANK_CNT=4`, `BANK_DEPTH=32`. Write address i with data i*3 for all 128 addresses, then read all → every `dout` matches and `rvalid` is high exactly one cycle after each `ren`.
- Random concurrent read/write traffic against a reference model → zero mismatches over 10k cycles. Coverage must hit conflict, forward, and blocked-write events.
